id_stage: RTL and testbench

Instruction-decode stage of the 8-bit RISC-V pipeline, directly downstream of instruction fetch. It holds the IF/ID pipeline register and decodes the captured instruction into control signals, register indices and an 8-bit immediate. It also contains the 32×8 register file, with write-back and same-cycle bypass, and detects load-use hazards, raising `stall` so that fetch holds its PC.

---
 rtl/id_stage_pkg.sv | 24 ++
 rtl/id_stage_if.sv | 49 ++++
 rtl/id_stage_reg_file.sv | 36 +++
 rtl/id_stage.sv | 141 ++++++++++++++
 tb/tb_id_stage.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/id_stage_pkg.sv
// Shared definitions for the instruction-decode stage of the 8-bit RISC-V pipeline.
// Holds opcode constants, the canonical NOP word, alu_op encodings and the default
// datapath width used by the stage, its interface and its register file.
package id_stage_pkg;

  localparam int unsigned DefaultDataWidth = 8;

  // addi x0, x0, 0
  localparam logic [31:0] NopInstr = 32'h0000_0013;

  localparam logic [6:0] OpcRtype  = 7'b0110011;
  localparam logic [6:0] OpcItype  = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  typedef enum logic [1:0] {
    AluAdd    = 2'b00,
    AluBranch = 2'b01,
    AluRtype  = 2'b10,
    AluItype  = 2'b11
  } alu_op_e;

endpackage

// File: rtl/id_stage_if.sv
// Bus between the decode stage and its neighbours: fetch inputs, write-back and EX
// hazard inputs, and all decoded outputs. The slave modport is the decode stage side;
// the master modport is the surrounding pipeline (or a bench) side.
interface id_stage_if #(
  parameter int unsigned PC_SIZE    = 32,
  parameter int unsigned DATA_WIDTH = id_stage_pkg::DefaultDataWidth
);
  logic [PC_SIZE-1:0]    PC_in;
  logic [31:0]           instruction_in;
  logic                  PCScr;
  logic                  reg_write_WB;
  logic [4:0]            rd_WB;
  logic [DATA_WIDTH-1:0] write_data_WB;
  logic                  mem_read_EX;
  logic [4:0]            rd_EX;

  logic                  stall;
  logic                  valid_ID;
  logic [PC_SIZE-1:0]    PC_ID;
  logic [DATA_WIDTH-1:0] read_data1;
  logic [DATA_WIDTH-1:0] read_data2;
  logic [DATA_WIDTH-1:0] imm;
  logic [4:0]            rs1;
  logic [4:0]            rs2;
  logic [4:0]            rd;
  logic [2:0]            funct3;
  logic                  funct7_b5;
  logic                  reg_write;
  logic                  mem_read;
  logic                  mem_write;
  logic                  alu_src;
  logic                  branch;
  logic [1:0]            alu_op;
  logic                  illegal;

  modport master (
    output PC_in, instruction_in, PCScr, reg_write_WB, rd_WB, write_data_WB, mem_read_EX,
           rd_EX,
    input  stall, valid_ID, PC_ID, read_data1, read_data2, imm, rs1, rs2, rd, funct3,
           funct7_b5, reg_write, mem_read, mem_write, alu_src, branch, alu_op, illegal
  );

  modport slave (
    input  PC_in, instruction_in, PCScr, reg_write_WB, rd_WB, write_data_WB, mem_read_EX,
           rd_EX,
    output stall, valid_ID, PC_ID, read_data1, read_data2, imm, rs1, rs2, rd, funct3,
           funct7_b5, reg_write, mem_read, mem_write, alu_src, branch, alu_op, illegal
  );
endinterface

// File: rtl/id_stage_reg_file.sv
// 32 x DATA_WIDTH register file: two asynchronous read ports, one write port.
// Ports: clock/reset (async, active-high), we/waddr/wdata write port,
// raddr1/raddr2 -> rdata1/rdata2 read ports. x0 is hardwired to zero and reads are
// write-first, so a same-cycle write to the read register is forwarded.
module id_stage_reg_file #(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  we,
  input  logic [4:0]            waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [4:0]            raddr1,
  input  logic [4:0]            raddr2,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] rdata2
);

  logic [DATA_WIDTH-1:0] regs_q [32];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) regs_q[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      regs_q[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (raddr1 != 5'd0) rdata1 = (we && (waddr == raddr1)) ? wdata : regs_q[raddr1];
    if (raddr2 != 5'd0) rdata2 = (we && (waddr == raddr2)) ? wdata : regs_q[raddr2];
  end

endmodule

// File: rtl/id_stage.sv
// Instruction-decode stage: IF/ID pipeline register, decoder, immediate generator,
// register file and load-use hazard detection.
// Ports: clock, reset (async, active-high), bus (id_stage_if.slave) carrying fetch
// inputs (PC_in, instruction_in, PCScr), write-back (reg_write_WB, rd_WB,
// write_data_WB), EX hazard info (mem_read_EX, rd_EX) and all decoded outputs.
module id_stage import id_stage_pkg::*; #(
  parameter int unsigned PC_SIZE    = 32,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
  input logic       clock,
  input logic       reset,
  id_stage_if.slave bus
);

  logic [PC_SIZE-1:0] pc_q;
  logic [31:0]        instr_q;
  logic               valid_q;
  logic               stall;

  // Flush beats stall so a taken branch never leaves a stale instruction behind.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= NopInstr;
      valid_q <= 1'b0;
    end else if (bus.PCScr) begin
      instr_q <= NopInstr;
      valid_q <= 1'b0;
    end else if (!stall) begin
      pc_q    <= bus.PC_in;
      instr_q <= bus.instruction_in;
      valid_q <= 1'b1;
    end
  end

  logic [6:0] opcode;
  logic [4:0] rs1, rs2;
  assign opcode = instr_q[6:0];
  assign rs1    = instr_q[19:15];
  assign rs2    = instr_q[24:20];

  logic    dec_reg_write, dec_mem_read, dec_mem_write, dec_alu_src, dec_branch, dec_illegal;
  logic    rs1_used, rs2_used;
  alu_op_e dec_alu_op;
  logic [31:0] imm_full;

  always_comb begin
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_alu_src   = 1'b0;
    dec_branch    = 1'b0;
    dec_illegal   = 1'b0;
    dec_alu_op    = AluAdd;
    rs1_used      = 1'b1;
    rs2_used      = 1'b0;
    case (opcode)
      OpcRtype: begin
        dec_reg_write = 1'b1;
        dec_alu_op    = AluRtype;
        rs2_used      = 1'b1;
      end
      OpcItype: begin
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_op    = AluItype;
      end
      OpcLoad: begin
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        dec_alu_src   = 1'b1;
      end
      OpcStore: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        rs2_used      = 1'b1;
      end
      OpcBranch: begin
        dec_branch = 1'b1;
        dec_alu_op = AluBranch;
        rs2_used   = 1'b1;
      end
      default: begin
        dec_illegal = 1'b1;
        rs1_used    = 1'b0;
      end
    endcase
  end

  // Full sign-extended immediate; only the low DATA_WIDTH bits leave the stage.
  always_comb begin
    case (opcode)
      OpcStore:  imm_full = {{20{instr_q[31]}}, instr_q[31:25], instr_q[11:7]};
      OpcBranch: imm_full = {{19{instr_q[31]}}, instr_q[31], instr_q[7], instr_q[30:25],
                             instr_q[11:8], 1'b0};
      default:   imm_full = {{20{instr_q[31]}}, instr_q[31:20]};
    endcase
  end

  logic unused_imm;
  assign unused_imm = ^imm_full[31:DATA_WIDTH];

  assign stall = valid_q && bus.mem_read_EX && (bus.rd_EX != 5'd0) &&
                 (((bus.rd_EX == rs1) && rs1_used) || ((bus.rd_EX == rs2) && rs2_used));

  // Bubble into EX whenever ID is empty or stalled.
  logic ctrl_en;
  assign ctrl_en = valid_q && !stall;

  assign bus.stall     = stall;
  assign bus.valid_ID  = valid_q;
  assign bus.PC_ID     = pc_q;
  assign bus.imm       = imm_full[DATA_WIDTH-1:0];
  assign bus.rs1       = rs1;
  assign bus.rs2       = rs2;
  assign bus.rd        = instr_q[11:7];
  assign bus.funct3    = instr_q[14:12];
  assign bus.funct7_b5 = instr_q[30];
  assign bus.reg_write = ctrl_en && dec_reg_write;
  assign bus.mem_read  = ctrl_en && dec_mem_read;
  assign bus.mem_write = ctrl_en && dec_mem_write;
  assign bus.alu_src   = ctrl_en && dec_alu_src;
  assign bus.branch    = ctrl_en && dec_branch;
  assign bus.illegal   = ctrl_en && dec_illegal;
  assign bus.alu_op    = ctrl_en ? dec_alu_op : AluAdd;

  id_stage_reg_file #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_reg_file (
    .clock  (clock),
    .reset  (reset),
    .we     (bus.reg_write_WB),
    .waddr  (bus.rd_WB),
    .wdata  (bus.write_data_WB),
    .raddr1 (rs1),
    .raddr2 (rs2),
    .rdata1 (bus.read_data1),
    .rdata2 (bus.read_data2)
  );

endmodule

// File: tb/tb_id_stage.sv
// Directed bench for id_stage: reset, decode of each format, load-use stall,
// write-back bypass, x0 handling, flush priority and reset during a stall.
module tb_id_stage;

  localparam int unsigned PcSize    = 32;
  localparam int unsigned DataWidth = 8;

  localparam logic [31:0] InstrAddi    = 32'h0050_0093; // addi x1,x0,5
  localparam logic [31:0] InstrAddiX3  = 32'h0001_8213; // addi x4,x3,0
  localparam logic [31:0] InstrAdd     = 32'h0011_01B3; // add x3,x2,x1
  localparam logic [31:0] InstrIllegal = 32'h0000_007F;
  localparam logic [31:0] InstrBranch  = 32'hFE20_8EE3; // beq x1,x2,-4
  localparam logic [31:0] InstrStore   = 32'h0020_A2A3; // sw x2,5(x1)
  localparam logic [31:0] InstrLoad    = 32'h0000_A103; // lw x2,0(x1)

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  id_stage_if #(.PC_SIZE(PcSize), .DATA_WIDTH(DataWidth)) bus ();

  id_stage #(
    .PC_SIZE    (PcSize),
    .DATA_WIDTH (DataWidth)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
    bus.PC_in          = pc;
    bus.instruction_in = instr;
  endtask

  initial begin
    bus.PC_in          = '0;
    bus.instruction_in = 32'h13;
    bus.PCScr          = 1'b0;
    bus.reg_write_WB   = 1'b0;
    bus.rd_WB          = '0;
    bus.write_data_WB  = '0;
    bus.mem_read_EX    = 1'b0;
    bus.rd_EX          = '0;

    tick();
    check("rst_valid", 32'(bus.valid_ID), 0);
    check("rst_pc", bus.PC_ID, 0);
    check("rst_stall", 32'(bus.stall), 0);
    check("rst_reg_write", 32'(bus.reg_write), 0);
    check("rst_illegal", 32'(bus.illegal), 0);
    check("rst_rdata1", 32'(bus.read_data1), 0);
    reset = 1'b0;

    // addi
    fetch(4, InstrAddi);
    tick();
    check("addi_rd", 32'(bus.rd), 1);
    check("addi_imm", 32'(bus.imm), 32'h05);
    check("addi_reg_write", 32'(bus.reg_write), 1);
    check("addi_alu_src", 32'(bus.alu_src), 1);
    check("addi_alu_op", 32'(bus.alu_op), 3);
    check("addi_pc", bus.PC_ID, 4);
    check("addi_valid", 32'(bus.valid_ID), 1);

    // x0 write is dropped, no bypass for x0
    bus.reg_write_WB = 1'b1; bus.rd_WB = 5'd0; bus.write_data_WB = 8'hFF;
    #1 check("x0_bypass", 32'(bus.read_data1), 0);
    tick();
    bus.reg_write_WB = 1'b0;
    #1 check("x0_write", 32'(bus.read_data1), 0);

    // load in EX writing x0 never stalls
    bus.mem_read_EX = 1'b1; bus.rd_EX = 5'd0;
    #1 check("rd_ex_zero_stall", 32'(bus.stall), 0);
    bus.mem_read_EX = 1'b0;

    // write-first bypass, then registered value
    fetch(8, InstrAddiX3);
    tick();
    bus.reg_write_WB = 1'b1; bus.rd_WB = 5'd3; bus.write_data_WB = 8'h2A;
    #1 check("bypass_rdata1", 32'(bus.read_data1), 32'h2A);
    check("bypass_rd", 32'(bus.rd), 4);
    tick();
    bus.reg_write_WB = 1'b0;
    #1 check("rf_rdata1", 32'(bus.read_data1), 32'h2A);

    // load-use stall on rs1
    fetch(12, InstrAdd);
    tick();
    check("add_alu_op", 32'(bus.alu_op), 2);
    check("add_rs1", 32'(bus.rs1), 2);
    check("add_rs2", 32'(bus.rs2), 1);
    bus.mem_read_EX = 1'b1; bus.rd_EX = 5'd2;
    fetch(16, InstrAddi);
    #1 check("lu_stall", 32'(bus.stall), 1);
    check("lu_reg_write", 32'(bus.reg_write), 0);
    check("lu_alu_op", 32'(bus.alu_op), 0);
    tick();
    check("lu_hold_pc", bus.PC_ID, 12);
    bus.mem_read_EX = 1'b0;
    #1 check("lu_release_stall", 32'(bus.stall), 0);
    check("lu_release_reg_write", 32'(bus.reg_write), 1);
    check("lu_release_rd", 32'(bus.rd), 3);

    // rs2 hazard together with flush: flush wins
    bus.mem_read_EX = 1'b1; bus.rd_EX = 5'd1;
    #1 check("rs2_stall", 32'(bus.stall), 1);
    bus.PCScr = 1'b1;
    tick();
    bus.PCScr = 1'b0; bus.mem_read_EX = 1'b0;
    #1 check("flush_valid", 32'(bus.valid_ID), 0);
    check("flush_reg_write", 32'(bus.reg_write), 0);
    check("flush_rd", 32'(bus.rd), 0);
    check("flush_stall", 32'(bus.stall), 0);

    // illegal opcode
    fetch(20, InstrIllegal);
    tick();
    check("ill_illegal", 32'(bus.illegal), 1);
    check("ill_reg_write", 32'(bus.reg_write), 0);
    check("ill_alu_src", 32'(bus.alu_src), 0);
    check("ill_mem_write", 32'(bus.mem_write), 0);

    // branch
    fetch(24, InstrBranch);
    tick();
    check("br_branch", 32'(bus.branch), 1);
    check("br_alu_op", 32'(bus.alu_op), 1);
    check("br_imm", 32'(bus.imm), 32'hFC);
    check("br_illegal", 32'(bus.illegal), 0);
    check("br_reg_write", 32'(bus.reg_write), 0);
    check("br_funct7_b5", 32'(bus.funct7_b5), 1);

    // store
    fetch(28, InstrStore);
    tick();
    check("sw_mem_write", 32'(bus.mem_write), 1);
    check("sw_alu_src", 32'(bus.alu_src), 1);
    check("sw_imm", 32'(bus.imm), 5);
    check("sw_reg_write", 32'(bus.reg_write), 0);

    // load
    fetch(32, InstrLoad);
    tick();
    check("lw_mem_read", 32'(bus.mem_read), 1);
    check("lw_reg_write", 32'(bus.reg_write), 1);
    check("lw_alu_op", 32'(bus.alu_op), 0);
    check("lw_funct3", 32'(bus.funct3), 2);

    // asynchronous reset in the middle of a stall
    fetch(36, InstrAdd);
    tick();
    bus.mem_read_EX = 1'b1; bus.rd_EX = 5'd2;
    #1 check("mid_stall", 32'(bus.stall), 1);
    #2 reset = 1'b1;
    #1 check("mid_rst_valid", 32'(bus.valid_ID), 0);
    check("mid_rst_pc", bus.PC_ID, 0);
    check("mid_rst_stall", 32'(bus.stall), 0);
    check("mid_rst_rd", 32'(bus.rd), 0);
    tick();
    reset = 1'b0; bus.mem_read_EX = 1'b0;
    fetch(40, InstrAddiX3);
    tick();
    check("rf_cleared", 32'(bus.read_data1), 0);
    check("post_rst_pc", bus.PC_ID, 40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
